// File: rtl/pdsch_dim_reduction_pkg.sv
// Shared constants, complex sample types and arithmetic helpers for the PDSCH
// dimension-reduction block.
package pdsch_dr_pkg;

  localparam int DEF_NUM_BEAMS = 16;
  localparam int DEF_ANT       = 32;
  localparam int DEF_IW        = 32;
  localparam int DEF_OW        = 48;
  localparam int DEF_LINK_IDX  = 0;

  localparam logic [3:0] SHIFT_CLAMP = 4'd9;
  localparam int         SYM_RES     = 1584;
  localparam int         RE_CNT_W    = 11;
  localparam int         SUM_W       = 35;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } cplx16_t;

  typedef struct packed {
    logic signed [47:0] i;
    logic signed [47:0] q;
  } cplx48_t;

  typedef struct packed {
    logic signed [SUM_W-1:0] i;
    logic signed [SUM_W-1:0] q;
  } cplx_sum_t;

  function automatic logic [3:0] clamp_shift(input logic [3:0] s);
    return (s > SHIFT_CLAMP) ? SHIFT_CLAMP : s;
  endfunction

  // Real part of a*c; 33 bits because both 32-bit products may reach +2^30.
  function automatic logic signed [32:0] cmul_re(input cplx16_t a, input cplx16_t c);
    logic signed [31:0] p0;
    logic signed [31:0] p1;
    p0 = $signed(a.i) * $signed(c.i);
    p1 = $signed(a.q) * $signed(c.q);
    return p0 - p1;
  endfunction

  function automatic logic signed [32:0] cmul_im(input cplx16_t a, input cplx16_t c);
    logic signed [31:0] p0;
    logic signed [31:0] p1;
    p0 = $signed(a.i) * $signed(c.q);
    p1 = $signed(a.q) * $signed(c.i);
    return p0 + p1;
  endfunction

endpackage

// File: rtl/pdsch_dim_reduction_unpack.sv
// dr_unpack_4ant: splits a CPRI word into four 7-bit I/Q pairs, holds the
// per-RB shift and registers the decompressed 16-bit samples.
module dr_unpack_4ant
  import pdsch_dr_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [63:0]         i_cpri_rx_data,
  input  logic [6:0]          i_cpri_rx_seq,
  input  logic                i_cpri_rx_vld,
  output cplx16_t [3:0]       o_ant,
  output logic                o_vld
);

  logic          w_rb_start;
  logic [3:0]    w_shift;
  logic [3:0]    r_shift;
  cplx16_t [3:0] w_ant;
  logic          w_unused_rsvd;

  assign w_unused_rsvd = ^i_cpri_rx_data[63:60];

  // The first word of an RB carries its shift and also uses it immediately.
  assign w_rb_start = (i_cpri_rx_seq % 7'd12) == 7'd0;
  assign w_shift    = w_rb_start ? clamp_shift(i_cpri_rx_data[59:56]) : r_shift;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_ant[k].i = {{9{i_cpri_rx_data[14*k+13]}}, i_cpri_rx_data[14*k+7 +: 7]} << w_shift;
      w_ant[k].q = {{9{i_cpri_rx_data[14*k+6]}},  i_cpri_rx_data[14*k   +: 7]} << w_shift;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_shift <= '0;
      o_ant   <= '0;
      o_vld   <= 1'b0;
    end else begin
      o_vld <= i_cpri_rx_vld;
      if (i_cpri_rx_vld) begin
        o_ant <= w_ant;
        if (w_rb_start) r_shift <= w_shift;
      end
    end
  end

endmodule

// File: rtl/pdsch_dim_reduction.sv
// pdsch_dim_reduction: 4-antenna to numBeams beamforming of CPRI REs, paired
// even/odd. Optional macro PDSCH_DR_CW_LATCH_EN latches code words per RBG.
module pdsch_dim_reduction
  import pdsch_dr_pkg::*;
#(
  parameter int numBeams = DEF_NUM_BEAMS,
  parameter int ANT      = DEF_ANT,
  parameter int IW       = DEF_IW,
  parameter int OW       = DEF_OW,
  parameter int LINK_IDX = DEF_LINK_IDX
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [63:0]                i_cpri_rx_data,
  input  logic [6:0]                 i_cpri_rx_seq,
  input  logic                       i_cpri_rx_vld,
  input  logic [numBeams*ANT*IW-1:0] i_code_word_even,
  input  logic [numBeams*ANT*IW-1:0] i_code_word_odd,
  input  logic [1:0]                 i_rbg_size,
  output logic [numBeams*2*OW-1:0]   o_ant_even,
  output logic [numBeams*2*OW-1:0]   o_ant_odd,
  output logic [9:0]                 o_ant_addr,
  output logic                       o_tvalid
);

  // Valid semantics: a word is consumed on every cycle with i_cpri_rx_vld=1
  // (no ready); o_tvalid is a one-cycle strobe and outputs hold between strobes.

  localparam int CW_W = $bits(cplx16_t);
  typedef cplx16_t [3:0] cw4_t;

  logic                w_unused;
  logic [RE_CNT_W-1:0] r_re_cnt;
  cw4_t                w_cw_even [numBeams];
  cw4_t                w_cw_odd  [numBeams];
  cw4_t                w_cw_sel  [numBeams];

  assign w_unused = ^{i_code_word_even, i_code_word_odd, i_rbg_size};

  always_ff @(posedge i_clk) begin
    if (!i_reset || !i_cpri_rx_vld) begin
      r_re_cnt <= '0;
    end else if (r_re_cnt == RE_CNT_W'(SYM_RES - 1)) begin
      r_re_cnt <= '0;
    end else begin
      r_re_cnt <= r_re_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int b = 0; b < numBeams; b++) begin
      for (int k = 0; k < 4; k++) begin
        w_cw_even[b][k] = i_code_word_even[IW*(b*ANT + 4*LINK_IDX + k) +: CW_W];
        w_cw_odd[b][k]  = i_code_word_odd[IW*(b*ANT + 4*LINK_IDX + k) +: CW_W];
      end
    end
  end

`ifdef PDSCH_DR_CW_LATCH_EN
  logic w_rbg_start;
  cw4_t r_lat_even [numBeams];
  cw4_t r_lat_odd  [numBeams];

  always_comb begin
    case (i_rbg_size)
      2'd0:    w_rbg_start = (r_re_cnt % RE_CNT_W'(12)) == '0;
      2'd1:    w_rbg_start = (r_re_cnt % RE_CNT_W'(24)) == '0;
      2'd2:    w_rbg_start = (r_re_cnt % RE_CNT_W'(48)) == '0;
      default: w_rbg_start = (r_re_cnt % RE_CNT_W'(96)) == '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int b = 0; b < numBeams; b++) begin
        r_lat_even[b] <= '0;
        r_lat_odd[b]  <= '0;
      end
    end else if (i_cpri_rx_vld && w_rbg_start) begin
      for (int b = 0; b < numBeams; b++) begin
        r_lat_even[b] <= w_cw_even[b];
        r_lat_odd[b]  <= w_cw_odd[b];
      end
    end
  end

  // The RBG's first RE bypasses the latch so it sees the word being captured.
  always_comb begin
    for (int b = 0; b < numBeams; b++) begin
      if (w_rbg_start) w_cw_sel[b] = r_re_cnt[0] ? w_cw_odd[b] : w_cw_even[b];
      else             w_cw_sel[b] = r_re_cnt[0] ? r_lat_odd[b] : r_lat_even[b];
    end
  end
`else
  always_comb begin
    for (int b = 0; b < numBeams; b++) begin
      w_cw_sel[b] = r_re_cnt[0] ? w_cw_odd[b] : w_cw_even[b];
    end
  end
`endif

  // Stage 1: decompressed samples, RE count and the matching code word.
  cplx16_t [3:0]       w_s1_ant;
  logic                w_s1_vld;
  logic [RE_CNT_W-1:0] r_s1_cnt;
  cw4_t                r_s1_cw [numBeams];

  dr_unpack_4ant u_unpack (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_cpri_rx_data (i_cpri_rx_data),
    .i_cpri_rx_seq  (i_cpri_rx_seq),
    .i_cpri_rx_vld  (i_cpri_rx_vld),
    .o_ant          (w_s1_ant),
    .o_vld          (w_s1_vld)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_s1_cnt <= '0;
      for (int b = 0; b < numBeams; b++) r_s1_cw[b] <= '0;
    end else if (i_cpri_rx_vld) begin
      r_s1_cnt <= r_re_cnt;
      for (int b = 0; b < numBeams; b++) r_s1_cw[b] <= w_cw_sel[b];
    end
  end

  // Stage 2: per-beam complex multiply-accumulate over the four antennas.
  cplx_sum_t           w_s2_sum [numBeams];
  cplx_sum_t           r_s2_sum [numBeams];
  logic                r_s2_vld;
  logic [RE_CNT_W-1:0] r_s2_cnt;

  always_comb begin : s2_mac
    logic signed [SUM_W-1:0] w_acc_i;
    logic signed [SUM_W-1:0] w_acc_q;
    for (int b = 0; b < numBeams; b++) begin
      w_acc_i = '0;
      w_acc_q = '0;
      for (int k = 0; k < 4; k++) begin
        w_acc_i = w_acc_i + cmul_re(w_s1_ant[k], r_s1_cw[b][k]);
        w_acc_q = w_acc_q + cmul_im(w_s1_ant[k], r_s1_cw[b][k]);
      end
      w_s2_sum[b].i = w_acc_i;
      w_s2_sum[b].q = w_acc_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_s2_vld <= 1'b0;
      r_s2_cnt <= '0;
      for (int b = 0; b < numBeams; b++) r_s2_sum[b] <= '0;
    end else begin
      r_s2_vld <= w_s1_vld;
      if (w_s1_vld) begin
        r_s2_cnt <= r_s1_cnt;
        for (int b = 0; b < numBeams; b++) r_s2_sum[b] <= w_s2_sum[b];
      end
    end
  end

  // Stage 3: park the even RE, release the pair when its odd partner arrives.
  cplx_sum_t  r_even_hold [numBeams];
  logic       r_even_ok;
  cplx_sum_t  r_s3_even [numBeams];
  cplx_sum_t  r_s3_odd  [numBeams];
  logic [9:0] r_s3_addr;
  logic       r_s3_vld;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_even_ok <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_s3_addr <= '0;
      for (int b = 0; b < numBeams; b++) begin
        r_even_hold[b] <= '0;
        r_s3_even[b]   <= '0;
        r_s3_odd[b]    <= '0;
      end
    end else begin
      r_s3_vld <= 1'b0;
      if (r_s2_vld && !r_s2_cnt[0]) begin
        r_even_ok <= 1'b1;
        for (int b = 0; b < numBeams; b++) r_even_hold[b] <= r_s2_sum[b];
      end else if (r_s2_vld) begin
        r_even_ok <= 1'b0;
        r_s3_vld  <= r_even_ok;
        r_s3_addr <= r_s2_cnt[RE_CNT_W-1:1];
        for (int b = 0; b < numBeams; b++) begin
          r_s3_even[b] <= r_even_hold[b];
          r_s3_odd[b]  <= r_s2_sum[b];
        end
      end
    end
  end

  // Stage 4: sign-extend into the output registers, which hold until the next pair.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_tvalid   <= 1'b0;
      o_ant_addr <= '0;
      o_ant_even <= '0;
      o_ant_odd  <= '0;
    end else begin
      o_tvalid <= r_s3_vld;
      if (r_s3_vld) begin
        o_ant_addr <= r_s3_addr;
        for (int b = 0; b < numBeams; b++) begin
          o_ant_even[b*2*OW +: 2*OW] <= {OW'($signed(r_s3_even[b].i)), OW'($signed(r_s3_even[b].q))};
          o_ant_odd[b*2*OW +: 2*OW]  <= {OW'($signed(r_s3_odd[b].i)),  OW'($signed(r_s3_odd[b].q))};
        end
      end
    end
  end

endmodule

// File: tb/tb_pdsch_dim_reduction.sv
// Directed bench for pdsch_dim_reduction: hand-computed pairs, a full-symbol
// stream through an expected queue, reset discard and code-word timing.
module tb_pdsch_dim_reduction;

  localparam int NB      = 16;
  localparam int ANT     = 32;
  localparam int IW      = 32;
  localparam int OW      = 48;
  localparam int SYM_RES = 1584;
  localparam int QW      = 10 + 4*OW;

  logic                  clk;
  logic                  rst;
  logic [63:0]           rx_data;
  logic [6:0]            rx_seq;
  logic                  rx_vld;
  logic [NB*ANT*IW-1:0]  cw_even;
  logic [NB*ANT*IW-1:0]  cw_odd;
  logic [1:0]            rbg_size;
  logic [NB*2*OW-1:0]    ant_even;
  logic [NB*2*OW-1:0]    ant_odd;
  logic [9:0]            ant_addr;
  logic                  tvalid;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 0;
  logic [QW-1:0] exp_q[$];

  pdsch_dim_reduction dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_cpri_rx_data   (rx_data),
    .i_cpri_rx_seq    (rx_seq),
    .i_cpri_rx_vld    (rx_vld),
    .i_code_word_even (cw_even),
    .i_code_word_odd  (cw_odd),
    .i_rbg_size       (rbg_size),
    .o_ant_even       (ant_even),
    .o_ant_odd        (ant_odd),
    .o_ant_addr       (ant_addr),
    .o_tvalid         (tvalid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  function automatic logic [63:0] mk_word(input logic [3:0] sh,
                                          input int i0, input int q0, input int i1, input int q1,
                                          input int i2, input int q2, input int i3, input int q3);
    logic [63:0] d;
    logic [31:0] vi[4];
    logic [31:0] vq[4];
    vi[0] = i0; vq[0] = q0; vi[1] = i1; vq[1] = q1;
    vi[2] = i2; vq[2] = q2; vi[3] = i3; vq[3] = q3;
    d = '0;
    d[59:56] = sh;
    for (int k = 0; k < 4; k++) begin
      d[14*k+7 +: 7] = vi[k][6:0];
      d[14*k   +: 7] = vq[k][6:0];
    end
    return d;
  endfunction

  task automatic set_cw(input bit odd, input int b, input int a, input int wi, input int wq);
    logic [31:0] vi;
    logic [31:0] vq;
    int idx;
    vi = wi;
    vq = wq;
    idx = IW*(b*ANT + a);
    if (odd) cw_odd[idx +: 32] = {vi[15:0], vq[15:0]};
    else     cw_even[idx +: 32] = {vi[15:0], vq[15:0]};
  endtask

  task automatic drive_word(input logic [6:0] seq, input logic [63:0] data);
    @(negedge clk);
    rx_vld  = 1'b1;
    rx_seq  = seq;
    rx_data = data;
  endtask

  task automatic do_pair(input string tag, input int beam, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [95:0] exp_e, input logic [95:0] exp_o);
    int lat;
    int npulse;
    drive_word(7'd0, d0);
    drive_word(7'd1, d1);
    lat = 0;
    npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) rx_vld = 1'b0;
      if (tvalid) begin
        npulse++;
        if (lat == 0) lat = i;
      end
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_pulses"}, npulse, 1);
    chk({tag, "_even"}, ant_even[beam*2*OW +: 2*OW], exp_e);
    chk({tag, "_odd"}, ant_odd[beam*2*OW +: 2*OW], exp_o);
    chk({tag, "_addr"}, ant_addr, 0);
  endtask

  function automatic longint cm_re(input longint ai, input longint aq, input longint wi, input longint wq);
    return ai*wi - aq*wq;
  endfunction

  function automatic longint cm_im(input longint ai, input longint aq, input longint wi, input longint wq);
    return ai*wq + aq*wi;
  endfunction

  task automatic push_pair(input int addr, input longint ei, input longint eq, input longint oi, input longint oq);
    exp_q.push_back({10'(addr), OW'(ei), OW'(eq), OW'(oi), OW'(oq)});
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (mon_en && tvalid) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
      else chk("stream_pair", {ant_addr, ant_even[2*OW-1:0], ant_odd[2*OW-1:0]}, exp_q.pop_front());
    end
  end

  initial begin
    int npulse;
    int thr;
    int sh_hold;
    longint ai, aq, e_i, e_q, o_i, o_q, w;

    rst = 1'b0;
    rx_vld = 1'b0;
    rx_seq = '0;
    rx_data = '0;
    cw_even = '0;
    cw_odd = '0;
    rbg_size = 2'd0;

    // reset held for 10 cycles
    npulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (tvalid) npulse++;
    end
    chk("rst_tvalid", npulse, 0);
    chk("rst_even", ant_even, 0);
    chk("rst_odd", ant_odd, 0);
    chk("rst_addr", ant_addr, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // unit weight, shift 0
    set_cw(0, 0, 0, 1, 0);
    do_pair("unit", 0, mk_word(0, 3, -2, 0, 0, 0, 0, 0, 0), mk_word(0, 3, -2, 0, 0, 0, 0, 0, 0),
            {48'sd3, -48'sd2}, 96'd0);

    // beam 3 sums antennas 0 and 2
    cw_even = '0; cw_odd = '0;
    set_cw(0, 3, 0, 2, 1);
    set_cw(0, 3, 2, -3, 4);
    set_cw(1, 3, 0, 1, 0);
    do_pair("beam3", 3, mk_word(0, 3, -2, 0, 0, -1, 5, 0, 0), mk_word(0, 3, -2, 0, 0, -1, 5, 0, 0),
            {-48'sd9, -48'sd20}, {48'sd3, -48'sd2});

    // shift 4 held onto the second word of the RB
    cw_even = '0; cw_odd = '0;
    set_cw(0, 0, 0, 1, 0);
    set_cw(1, 0, 0, 1, 0);
    do_pair("shift4", 0, mk_word(4, -64, 0, 0, 0, 0, 0, 0, 0), mk_word(0, -64, 0, 0, 0, 0, 0, 0, 0),
            {-48'sd1024, 48'sd0}, {-48'sd1024, 48'sd0});

    // shift 12 clamps to 9
    do_pair("clamp", 0, mk_word(12, 63, -1, 0, 0, 0, 0, 0, 0), mk_word(15, 63, -1, 0, 0, 0, 0, 0, 0),
            {48'sd32256, -48'sd512}, {48'sd32256, -48'sd512});

    // (1+1j)*(0+1j) on even, 2x real weight on odd
    cw_even = '0; cw_odd = '0;
    set_cw(0, 0, 0, 0, 1);
    set_cw(1, 0, 0, 2, 0);
    do_pair("cmplx", 0, mk_word(0, 1, 1, 0, 0, 0, 0, 0, 0), mk_word(0, 5, -7, 0, 0, 0, 0, 0, 0),
            {-48'sd1, 48'sd1}, {48'sd10, -48'sd14});

    // odd weight 2 doubles the even result
    set_cw(0, 0, 0, 1, 0);
    do_pair("double", 0, mk_word(0, 5, -7, 0, 0, 0, 0, 0, 0), mk_word(0, 5, -7, 0, 0, 0, 0, 0, 0),
            {48'sd5, -48'sd7}, {48'sd10, -48'sd14});

    // full-scale sum needs more than 32 bits
    cw_even = '0; cw_odd = '0;
    for (int k = 0; k < 4; k++) set_cw(0, 0, k, -32768, 32767);
    do_pair("fullscale", 0, mk_word(9, -64, -64, -64, -64, -64, -64, -64, -64),
            mk_word(9, -64, -64, -64, -64, -64, -64, -64, -64),
            {48'sd8589803520, 48'sd131072}, 96'd0);

    // reset between the odd RE and its output discards the pair
    drive_word(7'd0, mk_word(9, -64, -64, -64, -64, -64, -64, -64, -64));
    drive_word(7'd1, mk_word(9, -64, -64, -64, -64, -64, -64, -64, -64));
    @(negedge clk);
    rx_vld = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    npulse = 0;
    repeat (8) begin
      @(negedge clk);
      if (tvalid) npulse++;
    end
    chk("rstmid_pulses", npulse, 0);
    chk("rstmid_even", ant_even[2*OW-1:0], 0);

    // code word change at RE 5
`ifdef PDSCH_DR_CW_LATCH_EN
    thr = 24;
`else
    thr = 5;
`endif
    cw_even = '0; cw_odd = '0;
    set_cw(0, 0, 0, 1, 0);
    set_cw(1, 0, 0, 1, 0);
    rbg_size = 2'd1;
    mon_en = 1'b1;
    e_i = 0;
    for (int r = 0; r < 30; r++) begin
      @(negedge clk);
      if (r == 5) begin
        set_cw(0, 0, 0, 2, 0);
        set_cw(1, 0, 0, 2, 0);
      end
      rx_vld = 1'b1;
      rx_seq = 7'(r);
      rx_data = mk_word(0, (r % 5) + 1, 0, 0, 0, 0, 0, 0, 0);
      w = (r >= thr) ? 2 : 1;
      if (r % 2 == 0) e_i = ((r % 5) + 1) * w;
      else push_pair(r / 2, e_i, 0, ((r % 5) + 1) * w, 0);
    end
    @(negedge clk);
    rx_vld = 1'b0;
    repeat (10) @(negedge clk);
    chk("cwchg_drain", exp_q.size(), 0);
    rbg_size = 2'd0;

    // full symbol, wrap, then a trailing even RE that is dropped
    cw_even = '0; cw_odd = '0;
    set_cw(0, 0, 0, 2, -1);
    set_cw(1, 0, 0, -3, 1);
    sh_hold = 0;
    e_i = 0; e_q = 0;
    for (int r = 0; r < SYM_RES + 3; r++) begin
      int re;
      int dqi;
      int dqq;
      logic [3:0] sh_field;
      re = r % SYM_RES;
      dqi = (r % 128) - 64;
      dqq = 63 - (r % 97);
      if (re % 12 == 0) begin
        sh_hold = (re / 12) % 4;
        sh_field = 4'(sh_hold);
      end else begin
        sh_field = 4'hF;
      end
      ai = longint'(dqi) << sh_hold;
      aq = longint'(dqq) << sh_hold;
      drive_word(7'(re % 96), mk_word(sh_field, dqi, dqq, 0, 0, 0, 0, 0, 0));
      if (re % 2 == 0) begin
        e_i = cm_re(ai, aq, 2, -1);
        e_q = cm_im(ai, aq, 2, -1);
      end else begin
        o_i = cm_re(ai, aq, -3, 1);
        o_q = cm_im(ai, aq, -3, 1);
        push_pair(re / 2, e_i, e_q, o_i, o_q);
      end
    end
    @(negedge clk);
    rx_vld = 1'b0;
    repeat (12) @(negedge clk);
    chk("stream_drain", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdsch_dim_reduction.md
PDSCH_DIM_REDUCTION -- requirements
Module: pdsch_dim_reduction

Interface
REQ-001 The block SHALL have parameter numBeams, default 16: number of output beams.
REQ-002 The block SHALL have parameter ANT, default 32: number of antenna slots per code word.
REQ-003 The block SHALL have parameter IW, default 32: code-word entry width, {I[31:16], Q[15:0]}, signed.
REQ-004 The block SHALL have parameter OW, default 48: output I or Q width, signed.
REQ-005 The block SHALL have parameter LINK_IDX, default 0: selects code-word antennas 4*LINK_IDX..4*LINK_IDX+3.
REQ-006 The block SHALL have port i_clk, input, 1 bit: the single clock. Reset is synchronous and active-low.
REQ-007 The block SHALL have port i_reset, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port i_cpri_rx_data, input, 64 bits: one RE for 4 antennas; ant k = [14k+13:14k] = {I7,Q7}; [59:56] = shift; [63:60] reserved.
REQ-009 The block SHALL have port i_cpri_rx_seq, input, 7 bits: word index 0..95 (8 RB x 12 RE).
REQ-010 The block SHALL have port i_cpri_rx_vld, input, 1 bit: word valid.
REQ-011 The block SHALL have port i_code_word_even, input, numBeams x ANT*IW bits: weights for even REs; entry k at [IW*k+:IW].
REQ-012 The block SHALL have port i_code_word_odd, input, same width: weights for odd REs.
REQ-013 The block SHALL have port i_rbg_size, input, 2 bits: RBG = 1, 2, 4 or 8 RBs for codes 0..3.
REQ-014 The block SHALL have port o_ant_even, output, numBeams x 2*OW bits: even-RE beam result {I[95:48], Q[47:0]}.
REQ-015 The block SHALL have port o_ant_odd, output, numBeams x 2*OW bits: odd-RE beam result, same format.
REQ-016 The block SHALL have port o_ant_addr, output, 10 bits: RE-pair index 0..791.
REQ-017 The block SHALL have port o_tvalid, output, 1 bit: one-cycle strobe marking o_ant_even, o_ant_odd and o_ant_addr valid.

Function
REQ-018 The block SHALL accept a word on every cycle with i_cpri_rx_vld=1; there is no backpressure.
REQ-019 The block SHALL sample the shift at words with i_cpri_rx_seq mod 12 == 0 and hold it for that RB's 12 words.
REQ-020 The block SHALL clamp shift values greater than 9 to 9.
REQ-021 Decompression SHALL sign-extend each 7-bit I and Q value to 16 bits and arithmetic-left-shift it by the shift.
REQ-022 For each beam b, the result SHALL be the sum over k=0..3 of data[k]*cw[b][4*LINK_IDX+k] (complex): I = aI*cI - aQ*cQ, Q = aI*cQ + aQ*cI.
REQ-023 The full-precision sum (35 bits) SHALL be sign-extended to OW with no rounding or saturation.
REQ-024 An RE counter SHALL count valid words; even count uses the even code word, odd count uses the odd code word.
REQ-025 The RE counter SHALL clear whenever i_cpri_rx_vld=0 and SHALL wrap from 1583 to 0.
REQ-026 o_tvalid SHALL pulse exactly 4 cycles after the cycle carrying the odd RE of a pair.
REQ-027 o_ant_addr SHALL equal the pair's RE count divided by 2.
REQ-028 Outputs SHALL hold their values between o_tvalid pulses.
REQ-029 An even RE not followed by an odd RE (vld drops) SHALL be discarded with no o_tvalid.
REQ-030 Words already in the pipeline SHALL still complete when vld drops.

Reset
REQ-031 While i_reset=0 at a clock edge, all outputs, counters, the held shift, latched code words and pipeline valids SHALL be cleared to 0.
REQ-032 Reset asserted mid-pair or mid-pipeline SHALL discard all in-flight data.

Configuration
REQ-033 With macro PDSCH_DR_CW_LATCH_EN defined, both code words SHALL be latched at the first RE of each RBG (RE count mod (12*RBG) == 0) and used for that whole RBG.
REQ-034 Without PDSCH_DR_CW_LATCH_EN, code words SHALL be used directly every cycle and i_rbg_size SHALL be ignored.

Structure
REQ-035 Package pdsch_dr_pkg SHALL hold the default parameters, the shift clamp value 9, the 1584-RE symbol length and the complex sample typedefs (16-bit in, 48-bit out).
REQ-036 A single sub-module dr_unpack_4ant SHALL perform unpacking, shift hold and decompression for the 4 antennas.

Verification
REQ-037 Hold i_reset=0 for 10 cycles -> all outputs are 0 and o_tvalid stays 0.
REQ-038 Even beam0 ant0 = (1+0j), others 0; REs 0,1 carry ant0 I=3, Q=-2, shift 0 -> o_ant_even[0] = {48'sd3, -48'sd2}, addr 0, o_tvalid 4 cycles after RE 1.
REQ-039 Shift 4, I=-64, weight 1 -> I output is -1024; shift 12 with I=63 -> 63<<9 = 32256 (clamped).
REQ-040 Data (1+1j) with weight (0+1j) -> result (-1+1j); even weight 1 and odd weight 2 -> o_ant_odd is double o_ant_even.
REQ-041 Stream 1584 valid words -> addr runs 0..791 then wraps to 0; dropping vld after an even RE -> no pulse for that RE.
REQ-042 With PDSCH_DR_CW_LATCH_EN and i_rbg_size=1, change the code word at RE 5 -> change first takes effect at RE 24.
